// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: the decode/EX observations the pipeline feeds in,
// and the stall/flush controls plus debug status the controller drives back.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    // Decode-stage instruction fields
    logic [4:0]       IFID_Rs;
    logic [4:0]       IFID_Rt;
    logic             IFID_UsesRs;
    logic             IFID_UsesRt;
    logic             IFID_UsesHiLo;
    // EX-stage instruction attributes
    logic             DECEX_MemRead;
    logic             DECEX_RegWrite;
    logic [4:0]       DECEX_RegDst;
    logic             DECEX_MulDiv;
    logic             BranchTaken;
    // Controls back to the pipeline
    logic             PCWrite;
    logic             IFID_Write;
    logic             IFID_flush;
    logic             DECEX_stall;
    logic [1:0]       StallCause;
    logic             MulDivBusy;
    logic [CNT_W-1:0] BubbleCount;

    // Pipeline side: presents stage info, consumes controls
    modport master (
        output IFID_Rs, IFID_Rt, IFID_UsesRs, IFID_UsesRt, IFID_UsesHiLo,
        output DECEX_MemRead, DECEX_RegWrite, DECEX_RegDst, DECEX_MulDiv,
        output BranchTaken,
        input  PCWrite, IFID_Write, IFID_flush, DECEX_stall, StallCause,
        input  MulDivBusy, BubbleCount
    );

    // Controller side
    modport slave (
        input  IFID_Rs, IFID_Rt, IFID_UsesRs, IFID_UsesRt, IFID_UsesHiLo,
        input  DECEX_MemRead, DECEX_RegWrite, DECEX_RegDst, DECEX_MulDiv,
        input  BranchTaken,
        output PCWrite, IFID_Write, IFID_flush, DECEX_stall, StallCause,
        output MulDivBusy, BubbleCount
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage MIPS pipeline. Detects load-use
// hazards, taken-branch flushes and HiLo accesses behind the multi-cycle
// mult/div unit, and counts inserted bubbles (saturating) for debug.
module pipeline_hazard_ctrl #(
    parameter int MULDIV_LAT = 4,   // cycles the HiLo unit is occupied, 1..15
    parameter int CNT_W      = 16   // bubble counter width
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    pipeline_hazard_ctrl_if.slave  hz
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_MDBUSY = 1'b1
    } state_t;

    // The EX cycle itself is the first busy cycle, so the counter only
    // covers the remaining MULDIV_LAT-1 cycles.
    localparam logic [3:0] LP_BUSY_INIT = 4'(MULDIV_LAT - 1);
    localparam bit         LP_MULTI     = (MULDIV_LAT > 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_busy_cnt;
    logic [3:0]       w_busy_cnt_next;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic             w_load_use;
    logic             w_hilo_haz;
    logic             w_pc_write;
    logic             w_ifid_write;
    logic             w_ifid_flush;
    logic             w_decex_stall;
    logic [1:0]       w_stall_cause;
    logic             w_bubble;

    // Raw hazard detection from the decode and EX instructions
    always_comb begin
        w_load_use = hz.DECEX_MemRead & hz.DECEX_RegWrite &
                     (hz.DECEX_RegDst != 5'd0) &
                     ((hz.IFID_UsesRs & (hz.IFID_Rs == hz.DECEX_RegDst)) |
                      (hz.IFID_UsesRt & (hz.IFID_Rt == hz.DECEX_RegDst)));
        // The MulDiv term catches the start cycle, before MDBUSY is entered
        w_hilo_haz = hz.IFID_UsesHiLo &
                     ((r_state == ST_MDBUSY) | hz.DECEX_MulDiv);
    end

    // HiLo occupancy state register with its remaining-cycle counter
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state    <= ST_RUN;
            r_busy_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_next;
            r_busy_cnt <= w_busy_cnt_next;
        end
    end

    // Next state: a mult/div start arms the counter; branches never cancel it
    always_comb begin
        w_state_next    = r_state;
        w_busy_cnt_next = r_busy_cnt;
        case (r_state)
            ST_RUN: begin
                if (hz.DECEX_MulDiv && LP_MULTI) begin
                    w_state_next    = ST_MDBUSY;
                    w_busy_cnt_next = LP_BUSY_INIT;
                end
            end
            ST_MDBUSY: begin
                // A second start here is impossible (decode is stalled), so ignored
                if (r_busy_cnt <= 4'd1) begin
                    w_state_next    = ST_RUN;
                    w_busy_cnt_next = 4'd0;
                end else begin
                    w_busy_cnt_next = r_busy_cnt - 4'd1;
                end
            end
            default: begin
                w_state_next    = ST_RUN;
                w_busy_cnt_next = 4'd0;
            end
        endcase
    end

    // Prioritised stall/flush decode; reset forces a flush-and-bubble pattern
    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_decex_stall = 1'b0;
        w_stall_cause = 2'd0;
        if (!Rst_n) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_ifid_flush  = 1'b1;
            w_decex_stall = 1'b1;
            w_stall_cause = 2'd3;
        end else if (hz.BranchTaken) begin
            w_ifid_flush  = 1'b1;
            w_decex_stall = 1'b1;
            w_stall_cause = 2'd3;
        end else if (w_hilo_haz) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_decex_stall = 1'b1;
            w_stall_cause = 2'd2;
        end else if (w_load_use) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_decex_stall = 1'b1;
            w_stall_cause = 2'd1;
        end
    end

    // Bubbles forced during reset are never counted (reset branch wins)
    assign w_bubble = w_decex_stall;

    // Saturating bubble counter
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && (r_bubble_cnt != {CNT_W{1'b1}})) begin
            r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign hz.PCWrite     = w_pc_write;
    assign hz.IFID_Write  = w_ifid_write;
    assign hz.IFID_flush  = w_ifid_flush;
    assign hz.DECEX_stall = w_decex_stall;
    assign hz.StallCause  = w_stall_cause;
    assign hz.MulDivBusy  = Rst_n & (r_state == ST_MDBUSY);
    assign hz.BubbleCount = r_bubble_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (MULDIV_LAT=4, CNT_W=4).
// Stimulus pushes the hand-computed expected outputs per cycle; a negedge
// monitor pops and compares against what the DUT presents.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz_if ();

    pipeline_hazard_ctrl #(
        .MULDIV_LAT (4),
        .CNT_W      (CNT_W)
    ) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .hz    (hz_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected word: {PCWrite, IFID_Write, IFID_flush, DECEX_stall,
    //                 StallCause[1:0], MulDivBusy, BubbleCount[3:0]}
    logic [10:0] sb_q[$];
    string       nm_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [10:0] e_none(input logic b, input logic [3:0] bc);
        return {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, b, bc};
    endfunction
    function automatic logic [10:0] e_stall(input logic [1:0] c, input logic b, input logic [3:0] bc);
        return {1'b0, 1'b0, 1'b0, 1'b1, c, b, bc};
    endfunction
    function automatic logic [10:0] e_flush(input logic b, input logic [3:0] bc);
        return {1'b1, 1'b1, 1'b1, 1'b1, 2'd3, b, bc};
    endfunction
    function automatic logic [10:0] e_reset();
        return {1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 4'd0};
    endfunction

    task automatic push(input string nm, input logic [10:0] e);
        sb_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        hz_if.IFID_Rs        = 5'd0;
        hz_if.IFID_Rt        = 5'd0;
        hz_if.IFID_UsesRs    = 1'b0;
        hz_if.IFID_UsesRt    = 1'b0;
        hz_if.IFID_UsesHiLo  = 1'b0;
        hz_if.DECEX_MemRead  = 1'b0;
        hz_if.DECEX_RegWrite = 1'b0;
        hz_if.DECEX_RegDst   = 5'd0;
        hz_if.DECEX_MulDiv   = 1'b0;
        hz_if.BranchTaken    = 1'b0;
    endtask

    // EX holds a load to rd; decode reads rt==rd
    task automatic set_load_use(input logic [4:0] rd);
        hz_if.DECEX_MemRead  = 1'b1;
        hz_if.DECEX_RegWrite = 1'b1;
        hz_if.DECEX_RegDst   = rd;
        hz_if.IFID_UsesRt    = 1'b1;
        hz_if.IFID_Rt        = rd;
    endtask

    // Monitor: one comparison per presented cycle
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            logic [10:0] exp_w;
            logic [10:0] act_w;
            string       nm;
            exp_w = sb_q.pop_front();
            nm    = nm_q.pop_front();
            act_w = {hz_if.PCWrite, hz_if.IFID_Write, hz_if.IFID_flush,
                     hz_if.DECEX_stall, hz_if.StallCause, hz_if.MulDivBusy,
                     hz_if.BubbleCount};
            n_vec++;
            if (act_w !== exp_w) begin
                n_err++;
                $display("FAIL %s: got pcw/ifw/fl/st/cause/busy/bc=%b want %b", nm, act_w, exp_w);
            end else begin
                $display("ok   %s: pcw/ifw/fl/st/cause/busy/bc=%b", nm, act_w);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        clr_in();

        // Reset held
        next_cycle(); push("reset0", e_reset());
        next_cycle(); push("reset1", e_reset());
        next_cycle(); rst_n = 1'b1; push("release", e_none(1'b0, 4'd0));

        // Load-use on rt, then bubble in EX
        next_cycle(); clr_in(); set_load_use(5'd8);
        push("lu_rt", e_stall(2'd1, 1'b0, 4'd0));
        next_cycle(); hz_if.DECEX_MemRead = 1'b0; hz_if.DECEX_RegWrite = 1'b0; hz_if.DECEX_RegDst = 5'd0;
        push("lu_bubble", e_none(1'b0, 4'd1));

        // Both rs and rt match: still one cycle
        next_cycle(); clr_in(); set_load_use(5'd5); hz_if.IFID_UsesRs = 1'b1; hz_if.IFID_Rs = 5'd5;
        push("lu_rs_rt", e_stall(2'd1, 1'b0, 4'd1));
        next_cycle(); hz_if.DECEX_MemRead = 1'b0; hz_if.DECEX_RegWrite = 1'b0; hz_if.DECEX_RegDst = 5'd0;
        push("lu_rs_rt_bubble", e_none(1'b0, 4'd2));

        // Matching rt not read; rs read but different
        next_cycle(); clr_in(); set_load_use(5'd9); hz_if.IFID_UsesRt = 1'b0;
        hz_if.IFID_UsesRs = 1'b1; hz_if.IFID_Rs = 5'd3;
        push("lu_unused_rt", e_none(1'b0, 4'd2));

        // Register $0 never hazards
        next_cycle(); clr_in(); set_load_use(5'd0);
        push("lu_r0", e_none(1'b0, 4'd2));

        // ALU producer (no MemRead) is forwarded, no stall
        next_cycle(); clr_in(); set_load_use(5'd8); hz_if.DECEX_MemRead = 1'b0;
        push("alu_dep", e_none(1'b0, 4'd2));

        // HiLo busy: mult in EX at cycle 0, mflo waiting in decode
        next_cycle(); clr_in(); hz_if.DECEX_MulDiv = 1'b1; hz_if.IFID_UsesHiLo = 1'b1;
        push("hilo_c0", e_stall(2'd2, 1'b0, 4'd2));
        next_cycle(); hz_if.DECEX_MulDiv = 1'b0;
        push("hilo_c1", e_stall(2'd2, 1'b1, 4'd3));
        next_cycle(); push("hilo_c2", e_stall(2'd2, 1'b1, 4'd4));
        next_cycle(); push("hilo_c3", e_stall(2'd2, 1'b1, 4'd5));
        next_cycle(); push("hilo_c4_go", e_none(1'b0, 4'd6));

        // Mult start without HiLo reader, then flush with everything pending
        next_cycle(); clr_in(); hz_if.DECEX_MulDiv = 1'b1;
        push("md_start_nohilo", e_none(1'b0, 4'd6));
        next_cycle(); clr_in();
        push("md_busy_indep", e_none(1'b1, 4'd6));
        next_cycle(); clr_in(); set_load_use(5'd8); hz_if.IFID_UsesHiLo = 1'b1; hz_if.BranchTaken = 1'b1;
        push("flush_prio", e_flush(1'b1, 4'd6));
        next_cycle(); clr_in(); set_load_use(5'd8); hz_if.IFID_UsesHiLo = 1'b1;
        push("hilo_over_lu", e_stall(2'd2, 1'b1, 4'd7));
        next_cycle(); clr_in();
        push("md_done", e_none(1'b0, 4'd8));

        // Reset mid-op with two busy cycles left
        next_cycle(); clr_in(); hz_if.DECEX_MulDiv = 1'b1;
        push("md_start2", e_none(1'b0, 4'd8));
        next_cycle(); clr_in();
        push("md_busy2", e_none(1'b1, 4'd8));
        next_cycle(); rst_n = 1'b0;
        push("rst_midop", e_reset());
        next_cycle(); rst_n = 1'b1;
        push("rst_release", e_none(1'b0, 4'd0));
        next_cycle(); hz_if.IFID_UsesHiLo = 1'b1;
        push("rst_abandon", e_none(1'b0, 4'd0));

        // Saturation: 20 flush cycles on a 4-bit counter
        for (int k = 0; k < 20; k++) begin
            next_cycle(); clr_in(); hz_if.BranchTaken = 1'b1;
            push($sformatf("sat_%0d", k), e_flush(1'b0, (k > 15) ? 4'd15 : 4'(k)));
        end
        next_cycle(); clr_in();
        push("sat_hold", e_none(1'b0, 4'd15));

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Stall/flush controller for the 5-stage MIPS pipeline. It drives the PC write enable, the IF/ID hold and flush, and the DECEX_stall bubble input of the DEC/EX pipeline register.
- Detects load-use hazards, resolved-taken branches/jumps, and HiLo hazards behind the self-timed multi-cycle mult/div unit.
- Keeps a saturating count of inserted bubbles for performance debug.

Parameters:
- MULDIV_LAT, 4, total cycles a mult/div occupies the HiLo unit, counted from the cycle it sits in EX; legal range 1..15.
- CNT_W, 16, width of the bubble counter.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- IFID_Rs  in  5  rs field of the instruction in decode.
- IFID_Rt  in  5  rt field of the instruction in decode.
- IFID_UsesRs  in  1  decode instruction reads rs.
- IFID_UsesRt  in  1  decode instruction reads rt.
- IFID_UsesHiLo  in  1  decode instruction reads or writes Hi/Lo (mfhi/mflo/mthi/mtlo/mult/div/madd/msub).
- DECEX_MemRead  in  1  instruction in EX is a load.
- DECEX_RegWrite  in  1  instruction in EX writes the register file.
- DECEX_RegDst  in  5  destination register of the instruction in EX.
- DECEX_MulDiv  in  1  instruction in EX starts a mult/div.
- BranchTaken  in  1  EX resolved a taken branch, jump or jr this cycle.
- PCWrite  out  1  PC load enable.
- IFID_Write  out  1  IF/ID load enable.
- IFID_flush  out  1  IF/ID loads a NOP.
- DECEX_stall  out  1  DEC/EX loads all-zero (bubble).
- StallCause  out  2  0 none, 1 load-use, 2 HiLo busy, 3 flush.
- MulDivBusy  out  1  HiLo unit occupied (state MDBUSY).
- BubbleCount  out  CNT_W  saturating count of cycles with DECEX_stall=1.

Behaviour:
- Hazard outputs are combinational from inputs and state, with zero-cycle latency. BusyCnt, state and BubbleCount are registered.
- State machine:
  - RUN: on a rising edge with DECEX_MulDiv=1 and MULDIV_LAT>1, load BusyCnt=MULDIV_LAT-1 and go to MDBUSY.
  - MDBUSY: BusyCnt decrements each edge. When BusyCnt=1 at the edge, go to RUN with BusyCnt=0.
  - A DECEX_MulDiv pulse while in MDBUSY is ignored; this cannot occur legally because decode is stalled.
- Hazard conditions:
  - LoadUse = DECEX_MemRead & DECEX_RegWrite & (DECEX_RegDst!=0) & ((IFID_UsesRs & IFID_Rs==DECEX_RegDst) | (IFID_UsesRt & IFID_Rt==DECEX_RegDst)).
  - HiLoHaz = IFID_UsesHiLo & (state==MDBUSY | DECEX_MulDiv). The second term covers the mult/div start cycle.
- Priority, highest first:
  - BranchTaken: PCWrite=1, IFID_Write=1, IFID_flush=1, DECEX_stall=1, StallCause=3.
  - HiLoHaz: PCWrite=0, IFID_Write=0, IFID_flush=0, DECEX_stall=1, StallCause=2.
  - LoadUse: same outputs as HiLoHaz, StallCause=1.
  - None: PCWrite=1, IFID_Write=1, IFID_flush=0, DECEX_stall=0, StallCause=0.
- BranchTaken never cancels a running mult/div. BusyCnt keeps counting through a flush, because the op already left EX.
- Load-use with RegDst=0 is never a hazard. Both rs and rt matching is still a single one-cycle stall.
- The load-use stall lasts exactly one cycle: the bubble clears DECEX_MemRead on the next edge.
- BubbleCount increments on every edge with Rst_n=1 and DECEX_stall=1. It holds at all-ones and does not wrap.
- Reset (Rst_n=0, asynchronous, any cycle):
  - Registered values: state=RUN, BusyCnt=0, BubbleCount=0.
  - Forced outputs while Rst_n=0: PCWrite=0, IFID_Write=0, IFID_flush=1, DECEX_stall=1, StallCause=3, MulDivBusy=0.
  - Reset mid-MDBUSY abandons the count.
  - The first edge after deassertion evaluates normally; the bubbles inserted during reset are not counted.
- MULDIV_LAT=1: MDBUSY is never entered. HiLoHaz is raised only by the DECEX_MulDiv term.

Test Plan:
- Load-use: EX lw RegDst=8 with MemRead=1, RegWrite=1; ID UsesRt=1, Rt=8 -> one cycle of PCWrite=0, IFID_Write=0, DECEX_stall=1, StallCause=1. Next cycle, with EX holding the bubble, all outputs return to none and BubbleCount=1.
- Register $0: same as load-use but RegDst=0, Rt=0 -> no stall, StallCause=0.
- HiLo busy: MULDIV_LAT=4, DECEX_MulDiv=1 at cycle 0, ID mflo from cycle 0 -> stall cycles 0-3, MulDivBusy=1 cycles 1-3, mflo proceeds at cycle 4, BubbleCount=4.
- Flush priority: BranchTaken=1 with a load-use present and MDBUSY active, BusyCnt=2 -> PCWrite=1, IFID_flush=1, DECEX_stall=1, StallCause=3. BusyCnt still reaches 0 two edges later.
- Saturation: CNT_W=4, hold the flush for 20 cycles -> BubbleCount reaches 15 and stays 15.
- Reset mid-op: assert Rst_n=0 between edges while BusyCnt=2 -> outputs switch immediately to the forced reset values and MulDivBusy=0. After release with no hazards: PCWrite=1, DECEX_stall=0, BubbleCount=0.
